// File: rtl/memory_port_arbiter_pkg.sv
// Shared types and constants for the fetch/memory-stage RAM port arbiter.
// Holds FSM state encodings, access-size codes and the latched request record.
package memory_port_arbiter_pkg;

   typedef enum logic [2:0] {
      StIdle       = 3'd0,
      StAccess     = 3'd1,
      StWait       = 3'd2,
      StMergeWrite = 3'd3,
      StResp       = 3'd4
   } state_e;

   localparam logic True    = 1'b1;
   localparam logic False   = 1'b0;
   localparam logic MemWord = 1'b0;
   localparam logic MemByte = 1'b1;

   // Only the store byte is kept; full-word store data is consumed at grant.
   typedef struct packed {
      logic        is_fetch;
      logic        we;
      logic        size;
      logic [31:0] addr;
      logic [7:0]  wbyte;
   } req_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/memory_port_arbiter_byte_lane_unit.sv
// Combinational byte-lane helper: zero-extended lane extract and lane merge.
// Lane 0 is bits [7:0] (little-endian).
module byte_lane_unit (
   input  logic [31:0] word_i,
   input  logic [7:0]  byte_i,
   input  logic [1:0]  lane_i,
   output logic [31:0] extract_o,
   output logic [31:0] merge_o
);

   always_comb begin
      extract_o = 32'h0;
      merge_o   = word_i;
      unique case (lane_i)
         2'd0: begin
            extract_o[7:0] = word_i[7:0];
            merge_o[7:0]   = byte_i;
         end
         2'd1: begin
            extract_o[7:0] = word_i[15:8];
            merge_o[15:8]  = byte_i;
         end
         2'd2: begin
            extract_o[7:0] = word_i[23:16];
            merge_o[23:16] = byte_i;
         end
         2'd3: begin
            extract_o[7:0] = word_i[31:24];
            merge_o[31:24] = byte_i;
         end
         default: begin
            extract_o = 32'h0;
            merge_o   = word_i;
         end
      endcase
   end

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates the single RAM port between fetch and the memory stage and sequences
// each access (including read-modify-write byte stores) over a fixed-latency RAM.
module memory_port_arbiter
   import memory_port_arbiter_pkg::*;
#(
   parameter int unsigned RAM_LATENCY      = 1,
   parameter int unsigned FETCH_STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fe_in_req_l,
   input  logic [31:0] fe_in_address_l,
   output logic [31:0] fe_out_data_l,
   output logic        fe_out_ack_l,
   input  logic        mem_in_req_l,
   input  logic        mem_in_we_l,
   input  logic        mem_in_byte_l,
   input  logic [31:0] mem_in_address_l,
   input  logic [31:0] mem_in_wdata_l,
   output logic [31:0] mem_out_rdata_l,
   output logic        mem_out_ack_l,
   output logic        ram_out_en_l,
   output logic        ram_out_we_l,
   output logic [31:0] ram_out_address_l,
   output logic [31:0] ram_out_wdata_l,
   input  logic [31:0] ram_in_rdata_w
);

   localparam int unsigned CntW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
   localparam int unsigned StvW = $clog2(FETCH_STARVE_MAX + 1);
   localparam logic [StvW-1:0] StarveMax = StvW'(FETCH_STARVE_MAX);

   state_e            state_q, state_d;
   req_t              req_q, req_d;
   logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [StvW-1:0]   starve_q, starve_d;

   logic [31:0]       fe_data_q, fe_data_d;
   logic              fe_ack_q, fe_ack_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;
   logic              mem_ack_q, mem_ack_d;
   logic              ram_en_q, ram_en_d;
   logic              ram_we_q, ram_we_d;
   logic [31:0]       ram_addr_q, ram_addr_d;
   logic [31:0]       ram_wdata_q, ram_wdata_d;

   logic              grant_fe, grant_mem;
   req_t              grant_req;
   logic [31:0]       lane_extract, lane_merge;
   logic              is_word_store;

   byte_lane_unit u_byte_lane (
      .word_i    (ram_in_rdata_w),
      .byte_i    (req_q.wbyte),
      .lane_i    (req_q.addr[1:0]),
      .extract_o (lane_extract),
      .merge_o   (lane_merge)
   );

   // Memory stage has priority unless fetch has waited out its starvation budget.
   always_comb begin
      grant_fe           = fe_in_req_l && (!mem_in_req_l || (starve_q == StarveMax));
      grant_mem          = mem_in_req_l && !grant_fe;
      grant_req.is_fetch = grant_fe;
      grant_req.we       = grant_fe ? False : mem_in_we_l;
      grant_req.size     = grant_fe ? MemWord : mem_in_byte_l;
      grant_req.addr     = grant_fe ? fe_in_address_l : mem_in_address_l;
      grant_req.wbyte    = mem_in_wdata_l[7:0];
   end

   assign is_word_store = req_q.we && (req_q.size == MemWord);

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      wait_cnt_d  = wait_cnt_q;
      starve_d    = starve_q;
      fe_data_d   = 32'h0;
      fe_ack_d    = False;
      mem_rdata_d = 32'h0;
      mem_ack_d   = False;
      ram_en_d    = False;
      ram_we_d    = False;
      ram_addr_d  = 32'h0;
      ram_wdata_d = 32'h0;

      unique case (state_q)
         StIdle: begin
            if (grant_fe || grant_mem) begin
               req_d      = grant_req;
               state_d    = StAccess;
               ram_en_d   = True;
               ram_addr_d = word_align(grant_req.addr);
               if (grant_req.we && (grant_req.size == MemWord)) begin
                  ram_we_d    = True;
                  ram_wdata_d = mem_in_wdata_l;
               end
               if (grant_mem && fe_in_req_l) begin
                  if (starve_q != StarveMax) starve_d = starve_q + StvW'(1);
               end else begin
                  starve_d = '0;
               end
            end
         end

         StAccess: begin
            wait_cnt_d = CntW'(RAM_LATENCY - 1);
            if (is_word_store) begin
               state_d   = StResp;
               mem_ack_d = True;
            end else begin
               state_d = StWait;
            end
         end

         StWait: begin
            if (wait_cnt_q == '0) begin
               if (req_q.we) begin
                  state_d     = StMergeWrite;
                  ram_en_d    = True;
                  ram_we_d    = True;
                  ram_addr_d  = word_align(req_q.addr);
                  ram_wdata_d = lane_merge;
               end else begin
                  state_d = StResp;
                  if (req_q.is_fetch) begin
                     fe_ack_d  = True;
                     fe_data_d = ram_in_rdata_w;
                  end else begin
                     mem_ack_d   = True;
                     mem_rdata_d = (req_q.size == MemByte) ? lane_extract : ram_in_rdata_w;
                  end
               end
            end else begin
               wait_cnt_d = wait_cnt_q - CntW'(1);
            end
         end

         StMergeWrite: begin
            state_d   = StResp;
            mem_ack_d = True;
         end

         StResp: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         req_q       <= '0;
         wait_cnt_q  <= '0;
         starve_q    <= '0;
         fe_data_q   <= 32'h0;
         fe_ack_q    <= 1'b0;
         mem_rdata_q <= 32'h0;
         mem_ack_q   <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= 32'h0;
         ram_wdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         wait_cnt_q  <= wait_cnt_d;
         starve_q    <= starve_d;
         fe_data_q   <= fe_data_d;
         fe_ack_q    <= fe_ack_d;
         mem_rdata_q <= mem_rdata_d;
         mem_ack_q   <= mem_ack_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   assign fe_out_data_l     = fe_data_q;
   assign fe_out_ack_l      = fe_ack_q;
   assign mem_out_rdata_l   = mem_rdata_q;
   assign mem_out_ack_l     = mem_ack_q;
   assign ram_out_en_l      = ram_en_q;
   assign ram_out_we_l      = ram_we_q;
   assign ram_out_address_l = ram_addr_q;
   assign ram_out_wdata_l   = ram_wdata_q;

endmodule
